// File: rtl/tc_operand_loader_pkg.sv
// Shared types and default geometry for the tensor-core operand loader.
package tc_pkg;

  typedef enum logic [2:0] {
    FILL,
    ISSUE_LOAD,
    WAIT_LOAD,
    ISSUE_COMP,
    RUN
  } tc_state_e;

  localparam int TC_M              = 16;
  localparam int TC_N              = 16;
  localparam int TC_K              = 16;
  localparam int TC_DW_DATA        = 8;
  localparam int TC_BEAT_ELEMS     = 16;
  localparam int TC_LOAD_WAIT      = 3;
  localparam int TC_COMPUTE_CYCLES = 128;
  localparam int TC_DRAIN_CYCLES   = 16;

  localparam int TIMER_W = 16;

  function automatic int beatsFor(input int rows, input int cols, input int beatElems);
    return (rows * cols) / beatElems;
  endfunction

  localparam int BEATS_A     = beatsFor(TC_M, TC_K, TC_BEAT_ELEMS);
  localparam int BEATS_B     = beatsFor(TC_K, TC_N, TC_BEAT_ELEMS);
  localparam int BEATS_TOTAL = BEATS_A + BEATS_B;
  localparam int RUN_LEN     = TC_COMPUTE_CYCLES + TC_DRAIN_CYCLES;

endpackage

// File: rtl/tc_operand_loader_if.sv
// Beat stream carrying A then B^T into the operand loader.
interface tc_operand_loader_if #(
  parameter int BEAT_W = 128
) ();

  logic              s_valid;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data;
  logic              s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/tc_operand_loader_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module tc_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/tc_operand_loader.sv
// Assembles streamed A / B^T beats into flat operand buses and sequences the tensor core.
// Optional feature macro: TC_LOADER_PREFETCH_EN (accept next tile's beats during RUN).
module tc_operand_loader
  import tc_pkg::*;
#(
  parameter int M              = TC_M,
  parameter int N              = TC_N,
  parameter int K              = TC_K,
  parameter int DW_DATA        = TC_DW_DATA,
  parameter int BEAT_ELEMS     = TC_BEAT_ELEMS,
  parameter int LOAD_WAIT      = TC_LOAD_WAIT,
  parameter int COMPUTE_CYCLES = TC_COMPUTE_CYCLES,
  parameter int DRAIN_CYCLES   = TC_DRAIN_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  tc_operand_loader_if.slave     s_if,
  output logic                   o_loadEn,
  output logic                   o_computeEn,
  output logic [M*K*DW_DATA-1:0] o_matA,
  output logic [K*N*DW_DATA-1:0] o_matB,
  output logic                   o_busy,
  output logic                   o_tileDone,
  output logic                   o_errLast,
  output logic [15:0]            o_tileCount
);

  localparam int BW     = BEAT_ELEMS * DW_DATA;
  localparam int AW     = M * K * DW_DATA;
  localparam int BTW    = K * N * DW_DATA;
  localparam int NBA    = beatsFor(M, K, BEAT_ELEMS);
  localparam int NBB    = beatsFor(K, N, BEAT_ELEMS);
  localparam int NBT    = NBA + NBB;
  localparam int RLEN   = COMPUTE_CYCLES + DRAIN_CYCLES;
  localparam int CW     = $clog2(NBT + 1);
  localparam int OWA    = $clog2(AW);
  localparam int OWB    = $clog2(BTW);

  tc_state_e          r_state;
  tc_state_e          w_next;
  logic [CW-1:0]      r_beatCnt;
  logic [AW-1:0]      r_matA;
  logic [BTW-1:0]     r_matB;
  logic               r_errLast;
  logic [15:0]        r_tileCount;
  logic               w_ready;
  logic               w_accept;
  logic               w_finalBeat;
  logic               w_tileFilled;
  logic               w_timerLoad;
  logic [TIMER_W-1:0] w_timerValue;
  logic               w_timerDone;
  logic               w_tileDone;
  logic [OWA-1:0]     w_offA;
  logic [OWB-1:0]     w_offB;

  assign w_accept     = s_if.s_valid && w_ready;
  assign w_finalBeat  = (r_beatCnt == CW'(NBT - 1));
  assign w_tileFilled = w_accept && w_finalBeat;
  assign w_tileDone   = (r_state == RUN) && w_timerDone;
  assign w_offA       = OWA'(int'(r_beatCnt) * BW);
  assign w_offB       = OWB'((int'(r_beatCnt) - NBA) * BW);

  tc_cycle_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_timerLoad),
    .i_value(w_timerValue),
    .o_done (w_timerDone)
  );

`ifdef TC_LOADER_PREFETCH_EN
  // Prefetch opens from the third RUN cycle (core has left LOAD) until a full tile is held.
  logic [1:0] r_runAge;
  logic       r_fillDone;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_runAge   <= '0;
      r_fillDone <= 1'b0;
    end else begin
      if (r_state != RUN) begin
        r_runAge <= '0;
      end else if (r_runAge != 2'd2) begin
        r_runAge <= r_runAge + 1'b1;
      end
      if ((r_state == RUN) && w_tileFilled) begin
        r_fillDone <= 1'b1;
      end else if (r_state == ISSUE_LOAD) begin
        r_fillDone <= 1'b0;
      end
    end
  end

  assign w_ready = (r_state == FILL) ||
                   ((r_state == RUN) && (r_runAge == 2'd2) && !r_fillDone);
`else
  assign w_ready = (r_state == FILL);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_timerLoad  = 1'b0;
    w_timerValue = '0;
    case (r_state)
      FILL: begin
        if (w_tileFilled) begin
          w_next = ISSUE_LOAD;
        end
      end
      ISSUE_LOAD: begin
        w_next       = WAIT_LOAD;
        w_timerLoad  = 1'b1;
        w_timerValue = TIMER_W'(LOAD_WAIT - 1);
      end
      WAIT_LOAD: begin
        if (w_timerDone) begin
          w_next = ISSUE_COMP;
        end
      end
      ISSUE_COMP: begin
        w_next       = RUN;
        w_timerLoad  = 1'b1;
        w_timerValue = TIMER_W'(RLEN - 1);
      end
      RUN: begin
        if (w_timerDone) begin
`ifdef TC_LOADER_PREFETCH_EN
          w_next = (r_fillDone || w_tileFilled) ? ISSUE_LOAD : FILL;
`else
          w_next = FILL;
`endif
        end
      end
      default: begin
        w_next = FILL;
      end
    endcase
  end

  // An early s_last discards the partial tile; a missing one is flagged but the tile is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beatCnt <= '0;
      r_errLast <= 1'b0;
    end else if (w_accept) begin
      if (w_finalBeat) begin
        r_beatCnt <= '0;
        if (!s_if.s_last) begin
          r_errLast <= 1'b1;
        end
      end else if (s_if.s_last) begin
        r_beatCnt <= '0;
        r_errLast <= 1'b1;
      end else begin
        r_beatCnt <= r_beatCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_matA <= '0;
      r_matB <= '0;
    end else if (w_accept) begin
      if (r_beatCnt < CW'(NBA)) begin
        r_matA[w_offA +: BW] <= s_if.s_data;
      end else begin
        r_matB[w_offB +: BW] <= s_if.s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tileCount <= '0;
    end else if (w_tileDone) begin
      r_tileCount <= r_tileCount + 16'd1;
    end
  end

  assign s_if.s_ready = w_ready;
  assign o_loadEn     = (r_state == ISSUE_LOAD);
  assign o_computeEn  = (r_state == ISSUE_COMP);
  assign o_busy       = (r_state != FILL);
  assign o_tileDone   = w_tileDone;
  assign o_errLast    = r_errLast;
  assign o_tileCount  = r_tileCount;
  assign o_matA       = r_matA;
  assign o_matB       = r_matB;

endmodule

// File: tb/tb_tc_operand_loader.sv
// Scoreboard bench for tc_operand_loader: stimulus queues expected tiles, a monitor checks pulses.
module tb_tc_operand_loader;

  localparam int AW        = 2048;
  localparam int BEAT_W    = 128;
  localparam int LOAD_GAP  = 1;
  localparam int COMP_GAP  = 5;
  localparam int DONE_GAP  = 149;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          loadEn, compEn, busy, tileDone, errLast;
  logic [15:0]   tileCount;
  logic [AW-1:0] matA, matB;

  always #5 clk = ~clk;

  tc_operand_loader_if #(.BEAT_W(BEAT_W)) ifc ();

  tc_operand_loader dut (
    .clk        (clk),
    .reset      (reset),
    .s_if       (ifc),
    .o_loadEn   (loadEn),
    .o_computeEn(compEn),
    .o_matA     (matA),
    .o_matB     (matB),
    .o_busy     (busy),
    .o_tileDone (tileDone),
    .o_errLast  (errLast),
    .o_tileCount(tileCount)
  );

  typedef struct {
    int            loadCyc;
    int            compCyc;
    int            doneCyc;
    logic [15:0]   count;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    bit            chkMatDone;
  } exp_t;

  exp_t        sbQ[$];
  int          stage = 0;
  bit          countPending = 1'b0;
  logic [15:0] countExp = '0;
  logic [15:0] expCount = '0;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] elemVal(input int seed, input int beat, input int e);
    return 8'((seed * 37 + beat * 16 + e) & 255);
  endfunction

  function automatic logic [BEAT_W-1:0] beatData(input int seed, input int beat);
    logic [BEAT_W-1:0] d;
    for (int e = 0; e < 16; e++) d[e*8 +: 8] = elemVal(seed, beat, e);
    return d;
  endfunction

  function automatic logic [AW-1:0] refMat(input int seed, input int firstBeat);
    logic [AW-1:0] r;
    for (int b = 0; b < 16; b++) r[b*BEAT_W +: BEAT_W] = beatData(seed, firstBeat + b);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic checkMatrix(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = AW/8 - 1; i >= 0; i--) if (act[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s: element %0d got %0h expected %0h", name, bad,
               act[bad*8 +: 8], exp[bad*8 +: 8]);
    end
  endtask

  // Monitor: every DUT pulse is matched against the oldest queued tile.
  always @(negedge clk) begin
    if (!reset) begin
      if (countPending) begin
        checkOutput("tile_count", {16'd0, tileCount}, {16'd0, countExp});
        countPending = 1'b0;
      end
      if (loadEn) begin
        if (sbQ.size() == 0 || stage != 0) checkOutput("unexpected load_en", loadEn, 0);
        else begin
          checkOutput("load_en cycle", cycle, sbQ[0].loadCyc);
          checkMatrix("mat_a at load", matA, sbQ[0].a);
          checkMatrix("mat_b at load", matB, sbQ[0].b);
          stage = 1;
        end
      end
      if (compEn) begin
        if (sbQ.size() == 0 || stage != 1) checkOutput("unexpected compute_en", compEn, 0);
        else begin
          checkOutput("compute_en cycle", cycle, sbQ[0].compCyc);
          stage = 2;
        end
      end
      if (tileDone) begin
        if (sbQ.size() == 0 || stage != 2) checkOutput("unexpected tile_done", tileDone, 0);
        else begin
          checkOutput("tile_done cycle", cycle, sbQ[0].doneCyc);
          if (sbQ[0].chkMatDone) begin
            checkMatrix("mat_a at done", matA, sbQ[0].a);
            checkMatrix("mat_b at done", matB, sbQ[0].b);
          end
          countExp     = sbQ[0].count;
          countPending = 1'b1;
          void'(sbQ.pop_front());
          stage = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input int seed, input int lastBeat, input int nBeats,
                               input bit gaps, output int firstCyc, output int finalCyc);
    int b;
    int waitCnt;
    b = 0;
    waitCnt = 0;
    firstCyc = -1;
    finalCyc = -1;
    while (b < nBeats && waitCnt < 2000) begin
      @(negedge clk);
      ifc.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.s_data  = beatData(seed, b);
      ifc.s_last  = (b == lastBeat);
      if (ifc.s_valid && ifc.s_ready) begin
        if (b == 0) firstCyc = cycle;
        if (b == nBeats - 1) finalCyc = cycle;
        b++;
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end
    checkOutput("beats accepted", b, nBeats);
  endtask

  task automatic pushTile(input int seed, input int base, input bit chk);
    exp_t e;
    expCount     = expCount + 16'd1;
    e.loadCyc    = base + LOAD_GAP;
    e.compCyc    = base + COMP_GAP;
    e.doneCyc    = base + DONE_GAP;
    e.count      = expCount;
    e.a          = refMat(seed, 0);
    e.b          = refMat(seed, 16);
    e.chkMatDone = chk;
    sbQ.push_back(e);
  endtask

  task automatic dropValid();
    @(negedge clk);
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    checkOutput("idle reached", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first, fin, t3;
    logic [AW-1:0] zeroMat;
    zeroMat     = '0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.s_last  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst load_en", loadEn, 0);
    checkOutput("rst compute_en", compEn, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst tile_done", tileDone, 0);
    checkOutput("rst err_last", errLast, 0);
    checkOutput("rst tile_count", {16'd0, tileCount}, 0);
    checkOutput("rst s_ready", ifc.s_ready, 1);
    checkMatrix("rst mat_a", matA, zeroMat);
    reset = 1'b0;

    // Clean back-to-back tile
    applyStimulus(1, 31, 32, 1'b0, first, fin);
    pushTile(1, fin, 1'b1);
    dropValid();
    waitIdle(400);
    checkOutput("elem A(1,2)", {24'd0, matA[18*8 +: 8]}, 32'd55);
    checkOutput("elem Bt(3,5)", {24'd0, matB[53*8 +: 8]}, 32'd90);
    checkOutput("err_last clean", errLast, 0);

    // Tile with random valid gaps
    applyStimulus(2, 31, 32, 1'b1, first, fin);
    pushTile(2, fin, 1'b1);
    dropValid();
    waitIdle(400);

    // Early s_last discards the partial tile
    applyStimulus(7, 10, 11, 1'b0, first, fin);
    dropValid();
    checkOutput("err_last early", errLast, 1);
    repeat (20) @(negedge clk);
    checkOutput("busy after discard", busy, 0);

    // Stream held valid during RUN
    applyStimulus(3, 31, 32, 1'b0, first, fin);
    t3 = fin;
`ifdef TC_LOADER_PREFETCH_EN
    pushTile(3, t3, 1'b0);
    applyStimulus(4, 31, 32, 1'b0, first, fin);
    checkOutput("prefetch first accept", first, t3 + 8);
    pushTile(4, t3 + DONE_GAP, 1'b1);
    dropValid();
    waitIdle(800);
`else
    pushTile(3, t3, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      ifc.s_valid = 1'b1;
      ifc.s_last  = 1'b0;
      ifc.s_data  = beatData(9, i % 32);
      if (i == 8 || i == 40 || i == 99) checkOutput("s_ready in RUN", ifc.s_ready, 0);
    end
    dropValid();
    waitIdle(400);
`endif
    checkOutput("err_last sticky", errLast, 1);

    // Reset in RUN cycle 50
    applyStimulus(5, 31, 32, 1'b0, first, fin);
    pushTile(5, fin, 1'b1);
    dropValid();
    while (cycle < fin + 55) @(negedge clk);
    checkOutput("busy in RUN", busy, 1);
    reset = 1'b1;
    sbQ.delete();
    stage        = 0;
    countPending = 1'b0;
    expCount     = '0;
    @(negedge clk);
    checkOutput("mid rst tile_done", tileDone, 0);
    checkOutput("mid rst busy", busy, 0);
    checkOutput("mid rst err_last", errLast, 0);
    checkOutput("mid rst tile_count", {16'd0, tileCount}, 0);
    checkOutput("mid rst s_ready", ifc.s_ready, 1);
    checkMatrix("mid rst mat_b", matB, zeroMat);
    reset = 1'b0;
    repeat (150) @(negedge clk);

    // tile_count wrap
    force dut.r_tileCount = 16'hFFFF;
    @(negedge clk);
    release dut.r_tileCount;
    expCount = 16'hFFFF;
    applyStimulus(6, 31, 32, 1'b0, first, fin);
    pushTile(6, fin, 1'b1);
    dropValid();
    waitIdle(400);
    repeat (200) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
